// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory responder: FSM states, request bundle,
// and the address legality check used by the responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_WAIT = 2'd1,
        DMEM_ST_RESP = 2'd2
    } dmem_st_e;

    localparam logic [31:0] DMEM_NOP   = 32'h0;
    localparam int          DMEM_CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // Misaligned or beyond the last word of the array.
    function automatic logic dmem_bad(
        input logic [31:0] addr,
        input int          depth
    );
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data array with per-byte write enables and a registered
// read port; contents are never reset.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// touches the array on the edge entering RESP and holds the response.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
        DMEM_CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    dmem_st_e              state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  err_q, err_d;
    logic                  rd_ok_q, rd_ok_d;

    dmem_req_t     cur;
    logic          accept;
    logic          enter_resp;
    logic          bad;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    // With zero wait states the array is accessed on the accept edge,
    // so the live request is used before it is latched.
    always_comb begin
        cur.we    = req_we;
        cur.addr  = req_addr;
        cur.wdata = req_wdata;
        cur.be    = req_be;
        if (state_q != DMEM_ST_IDLE) begin
            cur = req_q;
        end
    end

    assign accept = (state_q == DMEM_ST_IDLE) &&
                    req_valid && req_ready_q;
    assign enter_resp =
        (accept && (WAIT_CYCLES == 0)) ||
        ((state_q == DMEM_ST_WAIT) && (cnt_q == '0));

    assign bad      = dmem_bad(cur.addr, DEPTH);
    assign ram_addr = cur.addr[AW+1:2];
    assign ram_we   = (enter_resp && cur.we && !bad) ?
                      cur.be : 4'b0000;
    assign ram_re   = enter_resp && !cur.we && !bad;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        rd_ok_d = rd_ok_q;
        unique case (state_q)
            DMEM_ST_IDLE: begin
                if (accept) begin
                    req_d = cur;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DMEM_ST_RESP;
                    end else begin
                        state_d = DMEM_ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            DMEM_ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DMEM_ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_ST_RESP: begin
                if (resp_ready) begin
                    state_d = DMEM_ST_IDLE;
                    err_d   = 1'b0;
                    rd_ok_d = 1'b0;
                end
            end
            default: state_d = DMEM_ST_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = bad;
            rd_ok_d = !cur.we && !bad;
        end
        req_ready_d  = (state_d == DMEM_ST_IDLE);
        resp_valid_d = (state_d == DMEM_ST_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= DMEM_ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rd_ok_q ? ram_rdata : DMEM_NOP;

endmodule
